// File: rtl/prbs31_pkg.sv
// Shared definitions for the PRBS31 loopback test sequencer.
// Contents:
//   state_t       encoded sequencer states (IDLE=0 .. DONE=5)
//   PRBS_LEN      PRBS31 register length, also the self-seed length in bits
//   DEFAULT_SEED  substitute for an all-zero seed (an all-zero LFSR never leaves zero)
//   TAP_HI/TAP_LO feedback taps of x^31 + x^28 + 1
//   fix_seed      replaces an all-zero seed with DEFAULT_SEED
//   prbs31_next   one LFSR step, shared reference for generator/checker models
package prbs31_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEED = 3'd2,
      ST_SYNC = 3'd3,
      ST_RUN  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam int          PRBS_LEN     = 31;
   localparam logic [30:0] DEFAULT_SEED = 31'h1;
   localparam int          TAP_HI       = 31;
   localparam int          TAP_LO       = 28;

   function automatic logic [30:0] fix_seed(input logic [30:0] s);
      logic [30:0] r;
      if (s == 31'h0) begin
         r = DEFAULT_SEED;
      end else begin
         r = s;
      end
      return r;
   endfunction

   function automatic logic [30:0] prbs31_next(input logic [30:0] s);
      return {s[29:0], s[TAP_HI-1] ^ s[TAP_LO-1]};
   endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset, clears the count
//   clr    synchronous clear (has priority over inc)
//   inc    count one event; ignored once the count is all-ones
//   count  current count
module prbs_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1'b1);

   // Count register: clear wins, then increment unless already saturated
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/prbs31_test_sequencer.sv
// Sequencer for a PRBS31 generator/checker loopback bit-error test.
// Seeds the generator, lets the checker self-seed from the received stream,
// waits for LOCK_CNT consecutive clean bits, runs a burst of burst_len bits
// (0 means 2**LEN_W), optionally inverts single bits, and counts errors.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   start, abort          test start pulse (IDLE/DONE only); abort to IDLE (wins)
//   burst_len, seed       burst length and generator seed, latched on start
//   inject                request one inverted bit during RUN
//   chk_err               checker mismatch, meaningful while chk_en=1
//   gen_load/gen_seed     generator seed load strobe and value
//   gen_en/gen_inv        generator advance / invert current bit
//   chk_load/chk_en       checker self-seed / advance+compare
//   busy, locked, done    status flags
//   sync_fail             lock not reached within SYNC_TIMEOUT cycles
//   err_cnt               saturating RUN error count
//   state                 encoded FSM state for debug
// All outputs are registered and are computed from the next state, so every
// strobe changes on the same edge that enters the state it belongs to.
module prbs31_test_sequencer
   import prbs31_pkg::*;
#(
   parameter int LEN_W        = 16,
   parameter int CNT_W        = 16,
   parameter int LOCK_CNT     = 64,
   parameter int SYNC_TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] burst_len,
   input  logic [30:0]      seed,
   input  logic             inject,
   input  logic             chk_err,
   output logic             gen_load,
   output logic [30:0]      gen_seed,
   output logic             gen_en,
   output logic             gen_inv,
   output logic             chk_load,
   output logic             chk_en,
   output logic             busy,
   output logic             locked,
   output logic             done,
   output logic             sync_fail,
   output logic [CNT_W-1:0] err_cnt,
   output logic [2:0]       state
);

   // One phase counter serves SEED, SYNC and RUN; it must hold both the
   // longest burst and the SYNC timeout count.
   localparam int TO_W = $clog2(SYNC_TIMEOUT) + 1;
   localparam int PH_W = (LEN_W > TO_W) ? LEN_W : TO_W;
   localparam int LK_W = $clog2(LOCK_CNT + 1);

   localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1'b1);
   localparam logic [PH_W-1:0]  SEED_LAST = PH_W'(PRBS_LEN - 1);
   localparam logic [PH_W-1:0]  SYNC_LAST = PH_W'(SYNC_TIMEOUT - 1);
   localparam logic [LK_W-1:0]  LK_ONE    = LK_W'(1'b1);
   localparam logic [LK_W-1:0]  LOCK_LAST = LK_W'(LOCK_CNT - 1);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1'b1);

   state_t           state_r;
   state_t           state_nx;
   logic [PH_W-1:0]  ph_r;
   logic [PH_W-1:0]  ph_nx;
   logic [LK_W-1:0]  clean_r;
   logic [LK_W-1:0]  clean_nx;
   logic [LEN_W-1:0] len_r;

   logic start_ok_s;
   logic lock_s;
   logic timeout_s;
   logic run_last_s;
   logic inject_req_s;
   logic err_inc_s;

   logic        gen_load_nx;
   logic [30:0] gen_seed_nx;
   logic        gen_en_nx;
   logic        gen_inv_nx;
   logic        chk_load_nx;
   logic        chk_en_nx;
   logic        busy_nx;
   logic        locked_nx;
   logic        done_nx;
   logic        sync_fail_nx;

   // Event decode for the current cycle
   always_comb begin
      start_ok_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && !abort;
      lock_s     = (state_r == ST_SYNC) && !chk_err && (clean_r == LOCK_LAST);
      timeout_s  = (state_r == ST_SYNC) && (ph_r == SYNC_LAST);
      // len_r - 1 wraps to all-ones for a zero length, giving 2**LEN_W bits
      run_last_s = (state_r == ST_RUN) && (ph_r[LEN_W-1:0] == (len_r - LEN_ONE));
      // gen_inv_r doubles as the pending flag: a request arriving while an
      // inversion is already scheduled is merged into it
      inject_req_s = (state_r == ST_RUN) && inject && !gen_inv;
      err_inc_s    = (state_r == ST_RUN) && chk_err && !abort;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state logic; abort overrides everything, lock wins over timeout
   always_comb begin
      state_nx = state_r;
      if (abort) begin
         state_nx = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_ok_s) begin
                  state_nx = ST_LOAD;
               end else begin
                  state_nx = state_r;
               end
            end
            ST_LOAD: state_nx = ST_SEED;
            ST_SEED: begin
               if (ph_r == SEED_LAST) begin
                  state_nx = ST_SYNC;
               end else begin
                  state_nx = ST_SEED;
               end
            end
            ST_SYNC: begin
               if (lock_s) begin
                  state_nx = ST_RUN;
               end else if (timeout_s) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_SYNC;
               end
            end
            ST_RUN: begin
               if (run_last_s) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_RUN;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // Phase and clean-run counters restart whenever the state changes
   always_comb begin
      if ((state_nx == state_r) &&
          ((state_r == ST_SEED) || (state_r == ST_SYNC) || (state_r == ST_RUN))) begin
         ph_nx = ph_r + PH_ONE;
      end else begin
         ph_nx = '0;
      end
      if ((state_r == ST_SYNC) && !chk_err) begin
         clean_nx = clean_r + LK_ONE;
      end else begin
         clean_nx = '0;
      end
   end

   // Counter and burst-length registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_r    <= '0;
         clean_r <= '0;
         len_r   <= '0;
      end else begin
         ph_r    <= ph_nx;
         clean_r <= clean_nx;
         if (start_ok_s) begin
            len_r <= burst_len;
         end else begin
            len_r <= len_r;
         end
      end
   end

   // Output decode from the state being entered
   always_comb begin
      gen_load_nx  = 1'b0;
      gen_seed_nx  = 31'h0;
      gen_en_nx    = 1'b0;
      gen_inv_nx   = 1'b0;
      chk_load_nx  = 1'b0;
      chk_en_nx    = 1'b0;
      busy_nx      = 1'b0;
      done_nx      = 1'b0;
      locked_nx    = locked;
      sync_fail_nx = sync_fail;
      case (state_nx)
         ST_LOAD: begin
            gen_load_nx = 1'b1;
            gen_seed_nx = fix_seed(seed);
            busy_nx     = 1'b1;
         end
         ST_SEED: begin
            gen_en_nx   = 1'b1;
            chk_en_nx   = 1'b1;
            chk_load_nx = 1'b1;
            busy_nx     = 1'b1;
         end
         ST_SYNC: begin
            gen_en_nx = 1'b1;
            chk_en_nx = 1'b1;
            busy_nx   = 1'b1;
         end
         ST_RUN: begin
            gen_en_nx  = 1'b1;
            chk_en_nx  = 1'b1;
            busy_nx    = 1'b1;
            gen_inv_nx = inject_req_s;
         end
         ST_DONE: done_nx = 1'b1;
         default: busy_nx = 1'b0;
      endcase
      if (abort || start_ok_s) begin
         locked_nx    = 1'b0;
         sync_fail_nx = 1'b0;
      end else if (lock_s) begin
         locked_nx = 1'b1;
      end else if (timeout_s) begin
         sync_fail_nx = 1'b1;
      end else begin
         locked_nx    = locked;
         sync_fail_nx = sync_fail;
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gen_load  <= 1'b0;
         gen_seed  <= 31'h0;
         gen_en    <= 1'b0;
         gen_inv   <= 1'b0;
         chk_load  <= 1'b0;
         chk_en    <= 1'b0;
         busy      <= 1'b0;
         locked    <= 1'b0;
         done      <= 1'b0;
         sync_fail <= 1'b0;
      end else begin
         gen_load  <= gen_load_nx;
         gen_seed  <= gen_seed_nx;
         gen_en    <= gen_en_nx;
         gen_inv   <= gen_inv_nx;
         chk_load  <= chk_load_nx;
         chk_en    <= chk_en_nx;
         busy      <= busy_nx;
         locked    <= locked_nx;
         done      <= done_nx;
         sync_fail <= sync_fail_nx;
      end
   end

   assign state = state_r;

   prbs_sat_counter #(
      .WIDTH (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_ok_s),
      .inc   (err_inc_s),
      .count (err_cnt)
   );

endmodule

// File: tb/tb_prbs31_test_sequencer.sv
// Directed bench for prbs31_test_sequencer with an ideal loopback model:
// chk_err follows gen_inv in the same compare cycle, plus bench-forced errors.
// Expected values are queued when a test is launched and popped when the
// DUT has produced the corresponding result.
module tb_prbs31_test_sequencer;

   localparam int LEN_W = 16;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [LEN_W-1:0] burst_len;
   logic [30:0]      seed;
   logic             inject;
   logic             chk_err;
   logic             gen_load;
   logic [30:0]      gen_seed;
   logic             gen_en;
   logic             gen_inv;
   logic             chk_load;
   logic             chk_en;
   logic             busy;
   logic             locked;
   logic             done;
   logic             sync_fail;
   logic [CNT_W-1:0] err_cnt;
   logic [2:0]       state;

   logic err_force;
   logic err_pulse;
   logic mon_clr;

   int n_tests = 0;
   int n_fail  = 0;
   int n_load  = 0;
   int n_chkld = 0;
   int n_sync  = 0;
   int n_run   = 0;
   int n_inv   = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   prbs31_test_sequencer #(
      .LEN_W        (LEN_W),
      .CNT_W        (CNT_W),
      .LOCK_CNT     (64),
      .SYNC_TIMEOUT (1024)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .burst_len (burst_len),
      .seed      (seed),
      .inject    (inject),
      .chk_err   (chk_err),
      .gen_load  (gen_load),
      .gen_seed  (gen_seed),
      .gen_en    (gen_en),
      .gen_inv   (gen_inv),
      .chk_load  (chk_load),
      .chk_en    (chk_en),
      .busy      (busy),
      .locked    (locked),
      .done      (done),
      .sync_fail (sync_fail),
      .err_cnt   (err_cnt),
      .state     (state)
   );

   always #5 clk = ~clk;

   // Ideal loopback: an inverted transmit bit shows up as a mismatch at once
   always_comb chk_err = err_force | err_pulse | (gen_inv & chk_en);

   // Per-test activity counters, sampled on the edge that ends each cycle
   always_ff @(posedge clk) begin
      if (mon_clr) begin
         n_load  <= 0;
         n_chkld <= 0;
         n_sync  <= 0;
         n_run   <= 0;
         n_inv   <= 0;
      end else begin
         n_load  <= n_load  + int'(gen_load);
         n_chkld <= n_chkld + int'(chk_load);
         n_sync  <= n_sync  + int'(state == 3'd3);
         n_run   <= n_run   + int'((state == 3'd4) && gen_en);
         n_inv   <= n_inv   + int'(gen_inv);
      end
   end

   function automatic logic [8:0] flags();
      return {gen_load, gen_en, gen_inv, chk_load, chk_en, busy, locked, done, sync_fail};
   endfunction

   task automatic exp_push(input string tag, input logic [31:0] v);
      sb_t e;
      e.tag = tag;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic exp_pop(input logic [31:0] obs);
      sb_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0h, no expected entry", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget);
      int k;
      k = 0;
      while ((state !== st) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      assert (state === st) else begin
         n_fail++;
         $error("FAIL wait_state: observed state %0d expected %0d within %0d cycles", state, st, budget);
      end
   endtask

   task automatic kick(input logic [30:0] s, input logic [LEN_W-1:0] len);
      seed      = s;
      burst_len = len;
      start     = 1'b1;
      mon_clr   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      mon_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; inject = 1'b0;
      burst_len = '0; seed = 31'h0; err_force = 1'b0; err_pulse = 1'b0; mon_clr = 1'b1;

      // Reset state
      @(negedge clk);
      exp_push("rst_state", 32'd0);  exp_pop(32'(state));
      exp_push("rst_flags", 32'd0);  exp_pop(32'(flags()));
      exp_push("rst_seed", 32'd0);   exp_pop(32'(gen_seed));
      exp_push("rst_errcnt", 32'd0); exp_pop(32'(err_cnt));
      rst = 1'b0;
      @(negedge clk);

      // 1: clean run, 100 bits
      exp_push("t1_seed", 32'h1);   exp_push("t1_state_load", 32'd1);
      exp_push("t1_gen_load", 32'd1); exp_push("t1_chk_load", 32'd31);
      exp_push("t1_sync_cycles", 32'd64); exp_push("t1_run_en", 32'd100);
      exp_push("t1_flags", 32'h006); exp_push("t1_errcnt", 32'd0);
      kick(31'h1, 16'd100);
      exp_pop(32'(gen_seed)); exp_pop(32'(state));
      wait_state(3'd5, 400);
      exp_pop(32'(n_load)); exp_pop(32'(n_chkld)); exp_pop(32'(n_sync));
      exp_pop(32'(n_run)); exp_pop(32'(flags())); exp_pop(32'(err_cnt));

      // 2: inject on RUN cycle 10, second inject on cycle 11 is merged
      exp_push("t2_seed", 32'h5A5A5A5); exp_push("t2_inv_cycles", 32'd1);
      exp_push("t2_errcnt", 32'd1); exp_push("t2_run_en", 32'd100);
      kick(31'h5A5A5A5, 16'd100);
      exp_pop(32'(gen_seed));
      wait_state(3'd4, 200);
      repeat (9) @(negedge clk);
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      wait_state(3'd5, 200);
      exp_pop(32'(n_inv)); exp_pop(32'(err_cnt)); exp_pop(32'(n_run));

      // 3: errors throughout SYNC -> timeout
      exp_push("t3_sync_cycles", 32'd1024); exp_push("t3_flags", 32'h003);
      exp_push("t3_errcnt", 32'd0); exp_push("t3_run_en", 32'd0);
      err_force = 1'b1;
      kick(31'h1234, 16'd100);
      wait_state(3'd5, 1200);
      err_force = 1'b0;
      exp_pop(32'(n_sync)); exp_pop(32'(flags())); exp_pop(32'(err_cnt)); exp_pop(32'(n_run));

      // 4: an error at clean count 63 restarts the lock count
      exp_push("t4_unlocked", 32'h3); exp_push("t4_sync_cycles", 32'd128);
      exp_push("t4_flags", 32'h006); exp_push("t4_run_en", 32'd20);
      kick(31'h7654321, 16'd20);
      wait_state(3'd3, 100);
      repeat (63) @(negedge clk);
      err_pulse = 1'b1;
      @(negedge clk);
      err_pulse = 1'b0;
      exp_pop(32'({locked, state[1:0]} ^ 3'b000) & 32'h7);
      wait_state(3'd5, 300);
      exp_pop(32'(n_sync)); exp_pop(32'(flags())); exp_pop(32'(n_run));

      // 5a: reset mid-RUN
      exp_push("t5a_state", 32'd0); exp_push("t5a_flags", 32'd0); exp_push("t5a_errcnt", 32'd0);
      kick(31'h55, 16'd100);
      wait_state(3'd4, 200);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      exp_pop(32'(state)); exp_pop(32'(flags())); exp_pop(32'(err_cnt));
      rst = 1'b0;
      @(negedge clk);

      // 5b: abort mid-SYNC
      exp_push("t5b_state", 32'd0); exp_push("t5b_flags", 32'd0); exp_push("t5b_seed", 32'd0);
      kick(31'h66, 16'd100);
      wait_state(3'd3, 100);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_pop(32'(state)); exp_pop(32'(flags())); exp_pop(32'(gen_seed));

      // 5c: abort mid-RUN after one injected error; err_cnt is held
      exp_push("t5c_errcnt_run", 32'd1); exp_push("t5c_state", 32'd0);
      exp_push("t5c_flags", 32'd0); exp_push("t5c_errcnt_held", 32'd1);
      kick(31'h77, 16'd100);
      wait_state(3'd4, 200);
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      @(negedge clk);
      exp_pop(32'(err_cnt));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_pop(32'(state)); exp_pop(32'(flags())); exp_pop(32'(err_cnt));

      // 5d: start and abort together -> stays IDLE, err_cnt not cleared
      exp_push("t5d_state", 32'd0); exp_push("t5d_flags", 32'd0); exp_push("t5d_errcnt", 32'd1);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      exp_pop(32'(state)); exp_pop(32'(flags())); exp_pop(32'(err_cnt));

      // 6: zero seed substituted; forced errors saturate the 4-bit counter
      exp_push("t6_seed", 32'h1); exp_push("t6_errcnt", 32'd15); exp_push("t6_run_en", 32'd40);
      kick(31'h0, 16'd40);
      exp_pop(32'(gen_seed));
      wait_state(3'd4, 200);
      err_force = 1'b1;
      wait_state(3'd5, 100);
      err_force = 1'b0;
      exp_pop(32'(err_cnt)); exp_pop(32'(n_run));

      // 7: burst_len=0 runs 2**LEN_W bits
      exp_push("t7_run_en", 32'd65536); exp_push("t7_flags", 32'h006);
      kick(31'h9, 16'd0);
      wait_state(3'd5, 70000);
      exp_pop(32'(n_run)); exp_pop(32'(flags()));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
